// File: rtl/n64_pkg.sv
// ============================================================================
// n64_pkg : command codes and receiver state encoding shared by the N64 blocks
// Revision: 1.0
// ============================================================================
`default_nettype none

package n64_pkg;

  localparam logic [7:0] CMD_IDENTITY = 8'h00;
  localparam logic [7:0] CMD_POLL     = 8'h01;
  localparam logic [7:0] CMD_READ     = 8'h02;
  localparam logic [7:0] CMD_WRITE    = 8'h03;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOW   = 2'd1,
    ST_HIGH  = 2'd2,
    ST_DRAIN = 2'd3
  } rx_state_t;

  // Commands followed by an address/data payload that this receiver skips
  function automatic logic is_payload_cmd(input logic [7:0] code);
    return (code == CMD_READ) || (code == CMD_WRITE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/n64_sync_edge.sv
// ============================================================================
// n64_sync_edge : 2-FF synchroniser for an idle-high line plus edge detect
// Revision: 1.0
// ============================================================================
`default_nettype none

module n64_sync_edge (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic d_in,
  output logic level,
  output logic fall,
  output logic rise
);

  logic [1:0] r_sync;
  logic       r_prev;

  // Reset to the idle-high level so release of reset never looks like an edge
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], d_in};
      r_prev <= r_sync[1];
    end
  end

  assign level = r_sync[1];
  assign fall  = r_prev & ~r_sync[1];
  assign rise  = ~r_prev & r_sync[1];

endmodule

`default_nettype wire

// File: rtl/n64_receive_command.sv
// ============================================================================
// n64_receive_command : decodes console command bytes on the N64 data line
// and pulses the matching response trigger after a valid stop bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module n64_receive_command
  import n64_pkg::*;
#(
  parameter int CYC_PER_US  = 50,
  parameter int THRESH_CYC  = 2 * CYC_PER_US,
  parameter int TIMEOUT_CYC = 8 * CYC_PER_US
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       n64d_in,
  input  logic       tx_busy,
  output logic [7:0] cmd_byte,
  output logic       cmd_valid,
  output logic       trig_identity,
  output logic       trig_poll,
  output logic       trig_reset,
  output logic       rx_err,
  output logic       rx_busy
);

  localparam logic [15:0] c_thresh  = 16'(THRESH_CYC);
  localparam logic [15:0] c_timeout = 16'(TIMEOUT_CYC);
  localparam logic [3:0]  c_nbits   = 4'd8;

  logic       w_level, w_fall, w_rise;
  rx_state_t  r_state, w_state_nxt;
  logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_sh, w_sh_nxt;
  logic [15:0] r_cnt;
  logic       w_commit, w_err, w_timeout, w_short;

  logic [7:0] r_cmd_byte;
  logic       r_cmd_valid, r_trig_identity, r_trig_poll, r_trig_reset, r_rx_err;

  n64_sync_edge u_sync (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .d_in    (n64d_in),
    .level   (w_level),
    .fall    (w_fall),
    .rise    (w_rise)
  );

  assign w_timeout = (r_cnt >= c_timeout);
  assign w_short   = (r_cnt <  c_thresh);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Edges are tested before timeouts so a coincident edge always wins
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_sh_nxt      = r_sh;
    w_commit      = 1'b0;
    w_err         = 1'b0;
    if (tx_busy) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            w_state_nxt   = ST_LOW;
            w_bit_cnt_nxt = 4'd0;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            if (r_bit_cnt < c_nbits) begin
              w_sh_nxt      = {r_sh[6:0], w_short};
              w_bit_cnt_nxt = r_bit_cnt + 4'd1;
              w_state_nxt   = ST_HIGH;
            end else begin
              w_commit    = w_short;
              w_err       = ~w_short;
              w_state_nxt = ST_IDLE;
            end
          end else if (w_timeout) begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            w_state_nxt = ST_LOW;
          end else if (w_timeout) begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if ((r_bit_cnt == c_nbits) && is_payload_cmd(r_sh)) begin
            w_state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Counter is cleared on each edge, so this is time since the last rise
          if (w_level && !w_rise && w_timeout) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt       <= 4'd0;
      r_sh            <= 8'h00;
      r_cnt           <= 16'h0000;
      r_cmd_byte      <= 8'h00;
      r_cmd_valid     <= 1'b0;
      r_trig_identity <= 1'b0;
      r_trig_poll     <= 1'b0;
      r_trig_reset    <= 1'b0;
      r_rx_err        <= 1'b0;
    end else begin
      r_bit_cnt <= w_bit_cnt_nxt;
      r_sh      <= w_sh_nxt;
      if (w_fall || w_rise) begin
        r_cnt <= 16'h0000;
      end else if (r_cnt != 16'hFFFF) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_commit) begin
        r_cmd_byte <= r_sh;
      end
      r_cmd_valid     <= w_commit;
      r_trig_identity <= w_commit && ((r_sh == CMD_IDENTITY) || (r_sh == CMD_RESET));
      r_trig_poll     <= w_commit && (r_sh == CMD_POLL);
      r_trig_reset    <= w_commit && (r_sh == CMD_RESET);
      r_rx_err        <= w_err;
    end
  end

  assign cmd_byte      = r_cmd_byte;
  assign cmd_valid     = r_cmd_valid;
  assign trig_identity = r_trig_identity;
  assign trig_poll     = r_trig_poll;
  assign trig_reset    = r_trig_reset;
  assign rx_err        = r_rx_err;
  assign rx_busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_n64_receive_command.sv
// ============================================================================
// tb_n64_receive_command : directed self-checking bench for n64_receive_command
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_n64_receive_command;

  logic       sys_clk;
  logic       rst_n;
  logic       n64d_in;
  logic       tx_busy;
  logic [7:0] cmd_byte;
  logic       cmd_valid, trig_identity, trig_poll, trig_reset, rx_err, rx_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // pulse monitors (only written by the negedge sampler)
  int n_valid = 0, n_ident = 0, n_poll = 0, n_rst = 0, n_both = 0, n_err = 0, n_busy = 0;
  int valid_cyc = 0, ident_cyc = 0, poll_cyc = 0, err_cyc = 0;
  // baselines (only written by the stimulus tasks)
  int b_valid, b_ident, b_poll, b_rst, b_both, b_err, b_busy;
  int stop_rise_cyc = 0, last_rise_cyc = 0;

  n64_receive_command dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .n64d_in       (n64d_in),
    .tx_busy       (tx_busy),
    .cmd_byte      (cmd_byte),
    .cmd_valid     (cmd_valid),
    .trig_identity (trig_identity),
    .trig_poll     (trig_poll),
    .trig_reset    (trig_reset),
    .rx_err        (rx_err),
    .rx_busy       (rx_busy)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc = cyc + 1;

  always @(negedge sys_clk) begin
    if (cmd_valid) begin n_valid = n_valid + 1; valid_cyc = cyc; end
    if (trig_identity) begin n_ident = n_ident + 1; ident_cyc = cyc; end
    if (trig_poll) begin n_poll = n_poll + 1; poll_cyc = cyc; end
    if (trig_reset) n_rst = n_rst + 1;
    if (trig_identity && trig_reset) n_both = n_both + 1;
    if (rx_err) begin n_err = n_err + 1; err_cyc = cyc; end
    if (rx_busy) n_busy = n_busy + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic snap();
    b_valid = n_valid; b_ident = n_ident; b_poll = n_poll; b_rst = n_rst;
    b_both = n_both; b_err = n_err; b_busy = n_busy;
  endtask

  task automatic send_bit(input logic b);
    n64d_in = 1'b0;
    wait_cyc(b ? 50 : 150);
    n64d_in = 1'b1;
    last_rise_cyc = cyc;
    wait_cyc(b ? 150 : 50);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_stop();
    n64d_in = 1'b0;
    wait_cyc(50);
    n64d_in = 1'b1;
    stop_rise_cyc = cyc;
    wait_cyc(50);
  endtask

  task automatic send_cmd(input logic [7:0] v);
    send_byte(v);
    send_stop();
  endtask

  task automatic test_reset();
    wait_cyc(3);
    checks++;
    if ({cmd_valid, trig_identity, trig_poll, trig_reset, rx_err, rx_busy} !== 6'b0) begin
      errors++; $display("FAIL reset_pulses: got %b expected 000000",
        {cmd_valid, trig_identity, trig_poll, trig_reset, rx_err, rx_busy});
    end
    checks++;
    if (cmd_byte !== 8'h00) begin
      errors++; $display("FAIL reset_cmd_byte: got %h expected 00", cmd_byte);
    end
    rst_n = 1'b1;
    wait_cyc(10);
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy: got %b expected 0", rx_busy);
    end
  endtask

  task automatic test_identity();
    snap();
    send_cmd(8'h00);
    wait_cyc(20);
    checks++;
    if (n_valid - b_valid !== 1) begin
      errors++; $display("FAIL id_valid_count: got %0d expected 1", n_valid - b_valid);
    end
    checks++;
    if (cmd_byte !== 8'h00) begin
      errors++; $display("FAIL id_cmd_byte: got %h expected 00", cmd_byte);
    end
    checks++;
    if ({n_ident - b_ident, n_poll - b_poll, n_rst - b_rst, n_err - b_err} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL id_triggers: got ident=%0d poll=%0d reset=%0d err=%0d expected 1/0/0/0",
        n_ident - b_ident, n_poll - b_poll, n_rst - b_rst, n_err - b_err);
    end
    checks++;
    if (ident_cyc - stop_rise_cyc !== 3) begin
      errors++; $display("FAIL id_latency: got %0d expected 3", ident_cyc - stop_rise_cyc);
    end
    checks++;
    if (valid_cyc !== ident_cyc) begin
      errors++; $display("FAIL id_valid_align: got valid@%0d expected ident@%0d", valid_cyc, ident_cyc);
    end
  endtask

  task automatic test_reset_cmd();
    snap();
    send_cmd(8'hFF);
    wait_cyc(20);
    checks++;
    if (cmd_byte !== 8'hFF) begin
      errors++; $display("FAIL ff_cmd_byte: got %h expected ff", cmd_byte);
    end
    checks++;
    if ({n_ident - b_ident, n_rst - b_rst, n_both - b_both} !== {32'd1, 32'd1, 32'd1}) begin
      errors++; $display("FAIL ff_triggers: got ident=%0d reset=%0d together=%0d expected 1/1/1",
        n_ident - b_ident, n_rst - b_rst, n_both - b_both);
    end
    checks++;
    if (n_poll - b_poll !== 0) begin
      errors++; $display("FAIL ff_poll: got %0d expected 0", n_poll - b_poll);
    end
  endtask

  task automatic test_mid_reset();
    snap();
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    rst_n = 1'b0;
    #5;
    checks++;
    if ({cmd_byte, cmd_valid, trig_identity, trig_poll, trig_reset, rx_err, rx_busy} !== 14'b0) begin
      errors++; $display("FAIL mrst_outputs: got byte=%h flags=%b expected 00/000000", cmd_byte,
        {cmd_valid, trig_identity, trig_poll, trig_reset, rx_err, rx_busy});
    end
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(20);
    checks++;
    if ((n_valid - b_valid) + (n_err - b_err) + (n_ident - b_ident) !== 0) begin
      errors++; $display("FAIL mrst_no_pulse: got valid=%0d err=%0d ident=%0d expected 0",
        n_valid - b_valid, n_err - b_err, n_ident - b_ident);
    end
    snap();
    send_cmd(8'h01);
    wait_cyc(20);
    checks++;
    if ({cmd_byte, 32'(n_poll - b_poll), 32'(n_valid - b_valid)} !== {8'h01, 32'd1, 32'd1}) begin
      errors++; $display("FAIL mrst_next_poll: got byte=%h poll=%0d valid=%0d expected 01/1/1",
        cmd_byte, n_poll - b_poll, n_valid - b_valid);
    end
  endtask

  task automatic test_drain();
    snap();
    send_byte(8'h02);
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_stop();
    wait_cyc(500);
    checks++;
    if ({n_valid - b_valid, n_ident - b_ident, n_poll - b_poll, n_err - b_err} !== 128'd0) begin
      errors++; $display("FAIL drain_quiet: got valid=%0d ident=%0d poll=%0d err=%0d expected 0",
        n_valid - b_valid, n_ident - b_ident, n_poll - b_poll, n_err - b_err);
    end
    checks++;
    if ({cmd_byte, rx_busy} !== {8'h01, 1'b0}) begin
      errors++; $display("FAIL drain_hold: got byte=%h busy=%b expected 01/0", cmd_byte, rx_busy);
    end
    snap();
    send_cmd(8'h00);
    wait_cyc(20);
    checks++;
    if ({cmd_byte, 32'(n_ident - b_ident), 32'(n_valid - b_valid)} !== {8'h00, 32'd1, 32'd1}) begin
      errors++; $display("FAIL drain_next_id: got byte=%h ident=%0d valid=%0d expected 00/1/1",
        cmd_byte, n_ident - b_ident, n_valid - b_valid);
    end
  endtask

  task automatic test_back_to_back();
    snap();
    send_cmd(8'h01);
    send_cmd(8'h00);
    wait_cyc(20);
    checks++;
    if ({n_poll - b_poll, n_ident - b_ident, n_valid - b_valid, n_err - b_err} !== {32'd1, 32'd1, 32'd2, 32'd0}) begin
      errors++; $display("FAIL b2b_counts: got poll=%0d ident=%0d valid=%0d err=%0d expected 1/1/2/0",
        n_poll - b_poll, n_ident - b_ident, n_valid - b_valid, n_err - b_err);
    end
    checks++;
    if (!(poll_cyc < ident_cyc)) begin
      errors++; $display("FAIL b2b_order: got poll@%0d ident@%0d expected poll first", poll_cyc, ident_cyc);
    end
    checks++;
    if (cmd_byte !== 8'h00) begin
      errors++; $display("FAIL b2b_cmd_byte: got %h expected 00", cmd_byte);
    end
  endtask

  task automatic test_timeout();
    snap();
    send_bit(1'b1);
    send_bit(1'b0);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++; $display("FAIL to_busy_mid: got %b expected 1", rx_busy);
    end
    send_bit(1'b1);
    send_bit(1'b0);
    wait_cyc(500);
    checks++;
    if ({n_err - b_err, n_valid - b_valid} !== {32'd1, 32'd0}) begin
      errors++; $display("FAIL to_counts: got err=%0d valid=%0d expected 1/0", n_err - b_err, n_valid - b_valid);
    end
    checks++;
    if (err_cyc - last_rise_cyc !== 404) begin
      errors++; $display("FAIL to_timing: got %0d expected 404", err_cyc - last_rise_cyc);
    end
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++; $display("FAIL to_busy_drop: got %b expected 0", rx_busy);
    end
  endtask

  task automatic test_tx_busy();
    snap();
    tx_busy = 1'b1;
    send_cmd(8'h00);
    wait_cyc(20);
    tx_busy = 1'b0;
    wait_cyc(5);
    checks++;
    if ({n_valid - b_valid, n_ident - b_ident, n_err - b_err, n_busy - b_busy} !== 128'd0) begin
      errors++; $display("FAIL txb_deaf: got valid=%0d ident=%0d err=%0d busy=%0d expected 0",
        n_valid - b_valid, n_ident - b_ident, n_err - b_err, n_busy - b_busy);
    end
    snap();
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    tx_busy = 1'b1;
    wait_cyc(3);
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++; $display("FAIL txb_abort: got busy=%b expected 0", rx_busy);
    end
    wait_cyc(500);
    tx_busy = 1'b0;
    wait_cyc(10);
    checks++;
    if ({n_err - b_err, n_valid - b_valid} !== 64'd0) begin
      errors++; $display("FAIL txb_silent: got err=%0d valid=%0d expected 0/0", n_err - b_err, n_valid - b_valid);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    n64d_in = 1'b1;
    tx_busy = 1'b0;
    test_reset();
    test_identity();
    test_reset_cmd();
    test_mid_reset();
    test_drain();
    test_back_to_back();
    test_timeout();
    test_tx_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
